// File: rtl/rv32_bus_arbiter.sv
// N-master to 1-slave round-robin bus arbiter; the grant is held until the slave completes.
// Optional busy timeout enabled by defining RV32_BUS_ARBITER_TIMEOUT_EN.
module rv32_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_address_in,
   input  logic [NUM_MASTERS-1:0]                m_read_in,
   input  logic [NUM_MASTERS-1:0]                m_write_in,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_write_mask_in,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_write_value_in,
   output logic [DATA_WIDTH-1:0]                 m_read_value_out,
   output logic [NUM_MASTERS-1:0]                m_ready_out,
   output logic [ADDR_WIDTH-1:0]                 address_out,
   output logic                                  read_out,
   output logic                                  write_out,
   output logic [DATA_WIDTH/8-1:0]               write_mask_out,
   output logic [DATA_WIDTH-1:0]                 write_value_out,
   input  logic [DATA_WIDTH-1:0]                 read_value_in,
   input  logic                                  ready_in,
   output logic                                  error_out
);

   localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned GW         = $clog2(NUM_MASTERS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          last_q, last_d;
   logic [NUM_MASTERS-1:0] req;
   logic [GW-1:0]          sel;
   logic                   sel_vld;

`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   assign req              = m_read_in | m_write_in;
   assign m_read_value_out = read_value_in;

   // Round-robin search starting one past the previous winner.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      sel     = '0;
      sel_vld = 1'b0;
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         idx = (32'(last_q) + k) % NUM_MASTERS;
         if (!sel_vld && req[GW'(idx)]) begin
            sel     = GW'(idx);
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      int unsigned g;
      g               = 32'(grant_q);
      state_d         = state_q;
      grant_d         = grant_q;
      last_d          = last_q;
      address_out     = '0;
      read_out        = 1'b0;
      write_out       = 1'b0;
      write_mask_out  = '0;
      write_value_out = '0;
      m_ready_out     = '0;
      error_out       = 1'b0;
`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
      cnt_d           = cnt_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (sel_vld) begin
               grant_d = sel;
               last_d  = sel;
               state_d = BUSY;
            end
         end
         BUSY: begin
            address_out          = m_address_in[g*ADDR_WIDTH +: ADDR_WIDTH];
            read_out             = m_read_in[grant_q];
            write_out            = m_write_in[grant_q];
            write_mask_out       = m_write_mask_in[g*MASK_WIDTH +: MASK_WIDTH];
            write_value_out      = m_write_value_in[g*DATA_WIDTH +: DATA_WIDTH];
            m_ready_out[grant_q] = ready_in;
            if (ready_in) begin
               state_d = IDLE;
            end
`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               m_ready_out[grant_q] = 1'b1;
               error_out            = 1'b1;
               state_d              = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM_MASTERS - 1);
`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter: a 2-master and a 3-master instance share clock and reset.
module tb_rv32_bus_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // 2-master instance
   logic [63:0] a_addr;
   logic [1:0]  a_rd, a_wr;
   logic [7:0]  a_mask;
   logic [63:0] a_wval;
   logic [31:0] a_rval;
   logic [1:0]  a_rdy;
   logic [31:0] a_addr_o;
   logic        a_rd_o, a_wr_o;
   logic [3:0]  a_mask_o;
   logic [31:0] a_wval_o;
   logic [31:0] a_rvin;
   logic        a_rdyin;
   logic        a_err;

   // 3-master instance
   logic [95:0] b_addr;
   logic [2:0]  b_rd, b_wr;
   logic [11:0] b_mask;
   logic [95:0] b_wval;
   logic [31:0] b_rval;
   logic [2:0]  b_rdy;
   logic [31:0] b_addr_o;
   logic        b_rd_o, b_wr_o;
   logic [3:0]  b_mask_o;
   logic [31:0] b_wval_o;
   logic [31:0] b_rvin;
   logic        b_rdyin;
   logic        b_err;

   rv32_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut_a (
      .clk(clk), .reset(reset),
      .m_address_in(a_addr), .m_read_in(a_rd), .m_write_in(a_wr),
      .m_write_mask_in(a_mask), .m_write_value_in(a_wval),
      .m_read_value_out(a_rval), .m_ready_out(a_rdy),
      .address_out(a_addr_o), .read_out(a_rd_o), .write_out(a_wr_o),
      .write_mask_out(a_mask_o), .write_value_out(a_wval_o),
      .read_value_in(a_rvin), .ready_in(a_rdyin), .error_out(a_err)
   );

   rv32_bus_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .reset(reset),
      .m_address_in(b_addr), .m_read_in(b_rd), .m_write_in(b_wr),
      .m_write_mask_in(b_mask), .m_write_value_in(b_wval),
      .m_read_value_out(b_rval), .m_ready_out(b_rdy),
      .address_out(b_addr_o), .read_out(b_rd_o), .write_out(b_wr_o),
      .write_mask_out(b_mask_o), .write_value_out(b_wval_o),
      .read_value_in(b_rvin), .ready_in(b_rdyin), .error_out(b_err)
   );

   // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_rd  = 2'b01;
      b_wr  = 3'b100;
      a_rvin = 32'h0000_0055;
      cyc();
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0)      begin errors++; $display("FAIL reset_a_read: got %b want 0", a_rd_o); end
      checks++; if (a_addr_o !== 32'h0)   begin errors++; $display("FAIL reset_a_addr: got %h want 0", a_addr_o); end
      checks++; if (a_rdy !== 2'b00)      begin errors++; $display("FAIL reset_a_ready: got %b want 00", a_rdy); end
      checks++; if (a_err !== 1'b0)       begin errors++; $display("FAIL reset_a_error: got %b want 0", a_err); end
      checks++; if (b_wr_o !== 1'b0)      begin errors++; $display("FAIL reset_b_write: got %b want 0", b_wr_o); end
      checks++; if (b_rdy !== 3'b000)     begin errors++; $display("FAIL reset_b_ready: got %b want 000", b_rdy); end
      checks++; if (a_rval !== 32'h55)    begin errors++; $display("FAIL rvalue_broadcast: got %h want 00000055", a_rval); end
      cyc();
      reset  = 1'b0;
      a_rd   = 2'b00;
      b_wr   = 3'b000;
      a_rvin = 32'h0;
   endtask

   task automatic test_single_read();
      a_addr[31:0] = 32'h0000_1000;
      a_rd = 2'b01;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0) begin errors++; $display("FAIL single_idle_read: got %b want 0", a_rd_o); end
      cyc();
      @(negedge clk);
      checks++; if (a_addr_o !== 32'h1000) begin errors++; $display("FAIL single_addr: got %h want 00001000", a_addr_o); end
      checks++; if (a_rd_o !== 1'b1)       begin errors++; $display("FAIL single_read: got %b want 1", a_rd_o); end
      checks++; if (a_rdy !== 2'b00)       begin errors++; $display("FAIL single_ready_early: got %b want 00", a_rdy); end
      cyc();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (a_rdy !== 2'b00 || a_rd_o !== 1'b1) begin errors++; $display("FAIL single_wait%0d: ready %b read %b want 00 1", i, a_rdy, a_rd_o); end
         cyc();
      end
      a_rdyin = 1'b1;
      a_rvin  = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (a_rdy !== 2'b01)          begin errors++; $display("FAIL single_ready: got %b want 01", a_rdy); end
      checks++; if (a_rval !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rvalue: got %h want deadbeef", a_rval); end
      cyc();
      a_rd = 2'b00;
      a_rdyin = 1'b0;
      a_rvin = 32'h0;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0 || a_rdy !== 2'b00) begin errors++; $display("FAIL single_back_idle: read %b ready %b want 0 00", a_rd_o, a_rdy); end
      cyc();
   endtask

   task automatic test_simultaneous();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      a_addr  = {32'h0000_00B0, 32'h0000_00A0};
      a_rd    = 2'b11;
      a_rdyin = 1'b1;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0 || a_rdy !== 2'b00) begin errors++; $display("FAIL simul_idle0: read %b ready %b want 0 00", a_rd_o, a_rdy); end
      cyc();
      @(negedge clk);
      checks++; if (a_addr_o !== 32'hA0) begin errors++; $display("FAIL simul_first_addr: got %h want 000000a0", a_addr_o); end
      checks++; if (a_rdy !== 2'b01)     begin errors++; $display("FAIL simul_first_ready: got %b want 01", a_rdy); end
      cyc();
      a_rd = 2'b10;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0 || a_rdy !== 2'b00) begin errors++; $display("FAIL simul_idle1: read %b ready %b want 0 00", a_rd_o, a_rdy); end
      cyc();
      @(negedge clk);
      checks++; if (a_addr_o !== 32'hB0 || a_rd_o !== 1'b1) begin errors++; $display("FAIL simul_second_req: addr %h read %b want 000000b0 1", a_addr_o, a_rd_o); end
      checks++; if (a_rdy !== 2'b10) begin errors++; $display("FAIL simul_second_ready: got %b want 10", a_rdy); end
      cyc();
      a_rd = 2'b00;
      a_rdyin = 1'b0;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0) begin errors++; $display("FAIL simul_end_idle: got %b want 0", a_rd_o); end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_addr [4] = '{32'h100, 32'h200, 32'h100, 32'h200};
      logic [1:0]  exp_rdy  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic        exp_wr   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      a_addr  = {32'h0000_0200, 32'h0000_0100};
      a_rd    = 2'b01;
      a_wr    = 2'b10;
      a_wval  = {32'hCAFE_0001, 32'h0};
      a_mask  = {4'hF, 4'h0};
      a_rdyin = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         checks++; if (a_rd_o !== 1'b0 || a_wr_o !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: read %b write %b want 0 0", t, a_rd_o, a_wr_o); end
         cyc();
         @(negedge clk);
         checks++; if (a_addr_o !== exp_addr[t]) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", t, a_addr_o, exp_addr[t]); end
         checks++; if (a_rdy !== exp_rdy[t])     begin errors++; $display("FAIL b2b_ready%0d: got %b want %b", t, a_rdy, exp_rdy[t]); end
         checks++; if (a_wr_o !== exp_wr[t])     begin errors++; $display("FAIL b2b_write%0d: got %b want %b", t, a_wr_o, exp_wr[t]); end
         cyc();
      end
      checks++; if (a_wval_o !== 32'h0) begin errors++; $display("FAIL b2b_idle_wvalue: got %h want 0", a_wval_o); end
      a_rd = 2'b00;
      a_wr = 2'b00;
      a_wval = '0;
      a_mask = '0;
      a_rdyin = 1'b0;
      cyc();
   endtask

   task automatic test_n3_write();
      b_addr[95:64] = 32'h0000_2000;
      b_wr          = 3'b100;
      b_mask[11:8]  = 4'b0011;
      b_wval[95:64] = 32'h1234_5678;
      b_rdyin       = 1'b0;
      @(negedge clk);
      checks++; if (b_wr_o !== 1'b0) begin errors++; $display("FAIL n3_idle: got %b want 0", b_wr_o); end
      cyc();
      @(negedge clk);
      checks++; if (b_wr_o !== 1'b1 || b_rd_o !== 1'b0) begin errors++; $display("FAIL n3_write: write %b read %b want 1 0", b_wr_o, b_rd_o); end
      checks++; if (b_mask_o !== 4'b0011)     begin errors++; $display("FAIL n3_mask: got %b want 0011", b_mask_o); end
      checks++; if (b_wval_o !== 32'h12345678) begin errors++; $display("FAIL n3_wvalue: got %h want 12345678", b_wval_o); end
      checks++; if (b_addr_o !== 32'h2000)    begin errors++; $display("FAIL n3_addr: got %h want 00002000", b_addr_o); end
      checks++; if (b_rdy !== 3'b000)         begin errors++; $display("FAIL n3_ready_early: got %b want 000", b_rdy); end
      cyc();
      b_rdyin = 1'b1;
      @(negedge clk);
      checks++; if (b_rdy !== 3'b100) begin errors++; $display("FAIL n3_ready: got %b want 100", b_rdy); end
      cyc();
      b_wr = 3'b000;
      b_rdyin = 1'b0;
      @(negedge clk);
      checks++; if (b_wr_o !== 1'b0 || b_rdy !== 3'b000) begin errors++; $display("FAIL n3_end_idle: write %b ready %b want 0 000", b_wr_o, b_rdy); end
      cyc();
   endtask

   task automatic test_reset_busy();
      a_addr[63:32] = 32'h0000_0300;
      a_rd    = 2'b10;
      a_rdyin = 1'b0;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0) begin errors++; $display("FAIL rbusy_idle: got %b want 0", a_rd_o); end
      cyc();
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b1 || a_addr_o !== 32'h300) begin errors++; $display("FAIL rbusy_b1: read %b addr %h want 1 00000300", a_rd_o, a_addr_o); end
      cyc();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b1) begin errors++; $display("FAIL rbusy_b2: got %b want 1", a_rd_o); end
      cyc();
      reset = 1'b0;
      a_addr[31:0] = 32'h0000_0400;
      a_rd = 2'b11;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0 || a_addr_o !== 32'h0 || a_rdy !== 2'b00) begin errors++; $display("FAIL rbusy_after_reset: read %b addr %h ready %b want 0 0 00", a_rd_o, a_addr_o, a_rdy); end
      cyc();
      @(negedge clk);
      checks++; if (a_addr_o !== 32'h400) begin errors++; $display("FAIL rbusy_regrant: got %h want 00000400", a_addr_o); end
      cyc();
      a_rdyin = 1'b1;
      @(negedge clk);
      checks++; if (a_rdy !== 2'b01) begin errors++; $display("FAIL rbusy_ready: got %b want 01", a_rdy); end
      cyc();
      a_rd = 2'b00;
      a_rdyin = 1'b0;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0) begin errors++; $display("FAIL rbusy_end_idle: got %b want 0", a_rd_o); end
      cyc();
   endtask

   task automatic test_timeout();
      a_addr[31:0] = 32'h0000_0500;
      a_rd    = 2'b01;
      a_rdyin = 1'b0;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %b want 0", a_rd_o); end
      cyc();
`ifdef RV32_BUS_ARBITER_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checks++; if (a_err !== (k == 8)) begin errors++; $display("FAIL tmo_err_c%0d: got %b want %b", k, a_err, (k == 8)); end
         checks++; if (a_rdy !== ((k == 8) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL tmo_ready_c%0d: got %b", k, a_rdy); end
         cyc();
      end
      a_rd = 2'b00;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL tmo_idle_after: read %b err %b want 0 0", a_rd_o, a_err); end
      cyc();
`else
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         checks++; if (a_err !== 1'b0 || a_rd_o !== 1'b1 || a_rdy !== 2'b00) begin errors++; $display("FAIL notmo_c%0d: err %b read %b ready %b want 0 1 00", k, a_err, a_rd_o, a_rdy); end
         cyc();
      end
      reset = 1'b1;
      a_rd  = 2'b00;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (a_rd_o !== 1'b0) begin errors++; $display("FAIL notmo_reset_idle: got %b want 0", a_rd_o); end
      cyc();
`endif
   endtask

   initial begin
      reset   = 1'b1;
      a_addr  = '0; a_rd = '0; a_wr = '0; a_mask = '0; a_wval = '0; a_rvin = '0; a_rdyin = 1'b0;
      b_addr  = '0; b_rd = '0; b_wr = '0; b_mask = '0; b_wval = '0; b_rvin = '0; b_rdyin = 1'b0;
      cyc();
      test_reset();
      test_single_read();
      test_simultaneous();
      test_back_to_back();
      test_n3_write();
      test_reset_busy();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv32_bus_arbiter.md
# rv32_bus_arbiter

Parametrised N-master to 1-slave memory bus arbiter with round-robin grant, for sharing one memory port between the core's instruction bus, its data bus and further masters (DMA, debug). It sits between the core's buses and a single memory/peripheral port. Both sides use the core bus protocol: address, read, write, write mask, write value, read value, ready. At most one master's transaction is forwarded at a time. The grant is held until the slave completes.

## Interface
- Reset is synchronous and active-high; the clock is `clk`, the reset is `reset`.
- NUM_MASTERS, default 2: number of masters, ≥ 2.
- ADDR_WIDTH, default 32: address width.
- DATA_WIDTH, default 32: data width, a multiple of 8. MASK_WIDTH = DATA_WIDTH/8.
- TIMEOUT_CYCLES, default 256: BUSY cycles before forced termination. Used only with RV32_BUS_ARBITER_TIMEOUT_EN. Must be ≥ 1.
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- m_address_in  input  NUM_MASTERS*ADDR_WIDTH  per-master address; master i occupies slice i
- m_read_in  input  NUM_MASTERS  per-master read request
- m_write_in  input  NUM_MASTERS  per-master write request
- m_write_mask_in  input  NUM_MASTERS*MASK_WIDTH  per-master byte mask
- m_write_value_in  input  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_read_value_out  output  DATA_WIDTH  read data, broadcast to all masters
- m_ready_out  output  NUM_MASTERS  per-master completion strobe
- address_out  output  ADDR_WIDTH  slave address
- read_out  output  1  slave read
- write_out  output  1  slave write
- write_mask_out  output  MASK_WIDTH  slave byte mask
- write_value_out  output  DATA_WIDTH  slave write data
- read_value_in  input  DATA_WIDTH  slave read data
- ready_in  input  1  slave completion
- error_out  output  1  timeout termination strobe

## Operation
- Master protocol:
  - A master asserts read or write and holds all of its request signals stable until it sees m_ready_out[i] high at a clock edge.
  - A master deasserts or changes its request in the cycle after completion.
  - Asserting read and write together is illegal. The arbiter forwards both unchanged.
- FSM states: IDLE and BUSY. Registers: grant (clog2 NUM_MASTERS bits) and last_grant.
- IDLE:
  - All slave outputs are 0 and m_ready_out is 0.
  - If any request (m_read_in[i] | m_write_in[i]) is present, the arbiter selects the first requester searching from last_grant+1 modulo NUM_MASTERS upward with wrap-around.
  - On the edge it registers grant = last_grant = selected and moves to BUSY.
- BUSY:
  - The slave outputs equal master[grant]'s inputs, combinationally.
  - m_ready_out[grant] = ready_in. All other m_ready_out bits are 0.
  - ready_in high: the FSM moves to IDLE on the edge.
- A request dropped by the granted master while in BUSY is a protocol violation. The outputs follow the master (read_out/write_out fall) and the arbiter waits for ready_in or a timeout.
- m_read_value_out = read_value_in at all times. Only m_ready_out identifies the recipient.
- Requests from non-granted masters are ignored until the next IDLE cycle. Masters are never starved: each waits at most NUM_MASTERS-1 transactions.

## Timing
- Reset values:
  - state IDLE, grant 0, last_grant NUM_MASTERS-1 (master 0 has first priority).
  - Timeout counter 0.
  - All slave outputs, m_ready_out and error_out are 0.
- Reset during BUSY abandons the slave transaction. The outputs are 0 from the cycle after the reset edge. The slave must tolerate the dropped request.
- Latency: request seen in cycle N (IDLE); slave request in N+1; completion in the ready_in cycle N+k; IDLE in N+k+1.
- Minimum 2 cycles per transaction (zero-wait slave). Re-arbitration happens in every IDLE cycle.
- A request newly arriving in the same cycle as another master's completion waits for the next IDLE cycle.

## Configuration
- RV32_BUS_ARBITER_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments in each BUSY cycle with ready_in low.
  - In the BUSY cycle where counter == TIMEOUT_CYCLES-1 and ready_in is low, the arbiter drives m_ready_out[grant]=1 and error_out=1 for that one cycle, then moves to IDLE.
  - m_read_value_out is undefined in that cycle.
  - ready_in high in that cycle is a normal completion with error_out=0.
- RV32_BUS_ARBITER_TIMEOUT_EN undefined: there is no counter, error_out is tied to 0, TIMEOUT_CYCLES is ignored, and BUSY waits indefinitely.

## Test plan
- Single read (N=2): master 0 reads 0x1000, slave asserts ready 3 cycles after read_out with 0xDEADBEEF. Required: address_out=0x1000 from the cycle after the request; m_ready_out=2'b01 in the ready cycle; master 0 receives 0xDEADBEEF; next cycle IDLE.
- Simultaneous requests after reset, zero-wait slave: master 0 is served first, master 1 second. The second slave request appears 2 cycles after the first.
- Both masters hold requests continuously (each re-requests immediately): grants alternate 0,1,0,1 across 4 transactions.
- N=3, DATA_WIDTH=32: master 2 writes 0x12345678 with mask 4'b0011. Required: write_out=1, write_mask_out=4'b0011, write_value_out=0x12345678; m_ready_out=3'b100 on ready_in.
- Reset asserted in the second BUSY cycle of a master 1 read. Required: outputs 0 the next cycle; with both masters requesting afterwards, master 0 is granted.
- Timeout enabled, TIMEOUT_CYCLES=8, ready_in held low. Required: error_out and m_ready_out[grant] pulse high in exactly the 8th BUSY cycle; IDLE follows. With the macro undefined, the arbiter stays in BUSY for 100 cycles with error_out 0.
